// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor
//   Bridges the cache's physical-memory port to a burst memory bus. Accepts one
//   full-line fill (read_i) or writeback (write_i) from the cache and performs a
//   BEATS-beat burst on the memory side (BEATS = LINE_W/BURST_W). When the burst
//   finishes, resp_o pulses for one cycle.
//
//   Optional feature: define CLA_TIMEOUT_EN to abort a burst when no beat arrives
//   for TIMEOUT cycles. The abort completes with resp_o=1 and err_o=1. Without the
//   macro, err_o is constant 0 and the block waits indefinitely for beats.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   line_i     writeback line from cache, sampled when a write is accepted
//   line_o     fill line to cache, valid while resp_o=1
//   address_i  cache request byte address
//   read_i     fill request (level, held until resp_o)
//   write_i    writeback request (level, held until resp_o); has priority over read_i
//   resp_o     one-cycle completion pulse
//   err_o      burst aborted by timeout; qualifies resp_o
//   burst_i    read beat data from memory
//   burst_o    write beat data to memory
//   address_o  line-aligned burst address
//   read_o     burst read request to memory
//   write_o    burst write request to memory
//   resp_i     memory beat strobe, one beat per high cycle
module cacheline_adaptor #(
    parameter int unsigned LINE_W  = 256,
    parameter int unsigned BURST_W = 64,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    input  logic [ADDR_W-1:0]  address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    output logic               err_o,
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic [ADDR_W-1:0]  address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);

    localparam int unsigned BEATS = LINE_W / BURST_W;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned OFF_W = $clog2(LINE_W / 8);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        DONE
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   beat_q;
    logic [CNT_W-1:0]   beat_d;
    logic [LINE_W-1:0]  wr_line_q;
    logic [LINE_W-1:0]  line_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [BURST_W-1:0] burst_q;
    logic               resp_q;
    logic               err_q;
    logic               read_q;
    logic               write_q;
    logic               timeout;
    int unsigned        cur_base;
    int unsigned        nxt_base;

    // Line offset bits never reach the burst bus.
    logic unused_addr_bits;
    assign unused_addr_bits = ^address_i[OFF_W-1:0];

    assign beat_d = beat_q + CNT_W'(1);

    always_comb begin
        cur_base = BURST_W * 32'(beat_q);
        nxt_base = BURST_W * 32'(beat_d);
    end

`ifdef CLA_TIMEOUT_EN
    localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TMR_W-1:0] tmr_q;

    // Cleared while idle (so it starts at 0 on burst entry) and on every beat.
    always_ff @(posedge clk) begin
        if (rst || state_q == IDLE || state_q == DONE || resp_i) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_q + TMR_W'(1);
        end
    end

    assign timeout = !resp_i && (tmr_q == TMR_W'(TIMEOUT - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT > 0);
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            wr_line_q <= '0;
            line_q    <= '0;
            addr_q    <= '0;
            burst_q   <= '0;
            resp_q    <= 1'b0;
            err_q     <= 1'b0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    resp_q <= 1'b0;
                    err_q  <= 1'b0;
                    beat_q <= '0;
                    if (write_i) begin
                        wr_line_q <= line_i;
                        burst_q   <= line_i[BURST_W-1:0];
                        addr_q    <= {address_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        write_q   <= 1'b1;
                        state_q   <= WR_BURST;
                    end else if (read_i) begin
                        addr_q  <= {address_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        read_q  <= 1'b1;
                        state_q <= RD_BURST;
                    end
                end
                RD_BURST: begin
                    if (resp_i) begin
                        line_q[cur_base +: BURST_W] <= burst_i;
                        beat_q <= beat_d;
                        if (beat_q == LAST_BEAT) begin
                            beat_q  <= '0;
                            read_q  <= 1'b0;
                            resp_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end else if (timeout) begin
                        beat_q  <= '0;
                        read_q  <= 1'b0;
                        resp_q  <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end
                end
                WR_BURST: begin
                    if (resp_i) begin
                        // Present the next beat the cycle after the strobe.
                        burst_q <= wr_line_q[nxt_base +: BURST_W];
                        beat_q  <= beat_d;
                        if (beat_q == LAST_BEAT) begin
                            beat_q  <= '0;
                            write_q <= 1'b0;
                            resp_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end else if (timeout) begin
                        beat_q  <= '0;
                        write_q <= 1'b0;
                        resp_q  <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    resp_q  <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign line_o    = line_q;
    assign resp_o    = resp_q;
    assign err_o     = err_q;
    assign burst_o   = burst_q;
    assign address_o = addr_q;
    assign read_o    = read_q;
    assign write_o   = write_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
module tb_cacheline_adaptor;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic         err_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    cacheline_adaptor #(
        .LINE_W (256),
        .BURST_W(64),
        .ADDR_W (32),
        .TIMEOUT(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .line_i   (line_i),
        .line_o   (line_o),
        .address_i(address_i),
        .read_i   (read_i),
        .write_i  (write_i),
        .resp_o   (resp_o),
        .err_o    (err_o),
        .burst_i  (burst_i),
        .burst_o  (burst_o),
        .address_o(address_o),
        .read_o   (read_o),
        .write_o  (write_o),
        .resp_i   (resp_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rd;
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] data;
        int           gap;
        logic [31:0]  exp_addr;
        int           exp_act;
        logic         exp_wr;
    } vec_t;

    typedef struct {
        logic         is_wr;
        logic [255:0] exp_line;
        int           exp_act;
    } exp_t;

    vec_t         vecs[5];
    exp_t         sb[$];
    int           pass_cnt  = 0;
    int           total_cnt = 0;
    logic [255:0] last_fill = '0;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        total_cnt++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    // Drives one cache request and acts as the memory. Entered just after a negedge.
    task automatic run_txn(input vec_t v);
        exp_t e;
        int   act;
        int   beat;
        int   gapc;
        bit   done;
        bit   first;
        bit   saw_rd;
        bit   saw_wr;
        e.is_wr    = v.exp_wr;
        e.exp_line = v.data;
        e.exp_act  = v.exp_act;
        sb.push_back(e);
        read_i    = v.rd;
        write_i   = v.wr;
        address_i = v.addr;
        line_i    = v.data;
        resp_i    = 1'b0;
        act = 0; beat = 0; gapc = 0; done = 0; first = 1; saw_rd = 0; saw_wr = 0;
        for (int c = 0; c < 80 && !done; c++) begin
            @(negedge clk);
            resp_i = 1'b0;
            if (resp_o) begin
                if (sb.size() == 0) begin
                    check("sb_nonempty", 1'b0, 1'b1);
                end else begin
                    e = sb.pop_front();
                    if (e.is_wr) begin
                        check("line_hold", line_o, last_fill);
                    end else begin
                        check("fill_line", line_o, e.exp_line);
                        last_fill = e.exp_line;
                    end
                    check("active_cycles", 32'(act), 32'(e.exp_act));
                    check("write_o_seen", saw_wr, e.is_wr);
                    check("read_o_seen", saw_rd, !e.is_wr);
                    check("err_o_clear", err_o, 1'b0);
                end
                read_i  = 1'b0;
                write_i = 1'b0;
                done    = 1;
            end else if (read_o || write_o) begin
                act++;
                saw_rd |= read_o;
                saw_wr |= write_o;
                if (first) begin
                    check("address_o", address_o, v.exp_addr);
                    first = 0;
                end
                if (gapc == 0) begin
                    resp_i = 1'b1;
                    gapc   = v.gap;
                    if (read_o) begin
                        burst_i = v.data[64*beat +: 64];
                    end else begin
                        check("burst_o_beat", burst_o, v.data[64*beat +: 64]);
                    end
                    beat++;
                end else begin
                    gapc--;
                    burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
                end
            end
            if (c == 0) begin
                // Request inputs change after accept; the burst must not notice.
                address_i = ~v.addr;
                line_i    = ~v.data;
            end
        end
        check("resp_arrived", done, 1'b1);
        @(negedge clk);
        check("resp_single", {resp_o, read_o, write_o}, 3'b000);
    endtask

    initial begin : main
        int   n;
        bit   done;
        logic [255:0] nt_data;

        vecs[0] = '{1'b1, 1'b0, 32'h0000_1234,
                    {64'hA3A3_A3A3_0000_0003, 64'hA2A2_A2A2_0000_0002,
                     64'hA1A1_A1A1_0000_0001, 64'hA0A0_A0A0_0000_0000},
                    0, 32'h0000_1220, 4, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 32'hDEAD_BEEF,
                    {64'hD3D3_0000_1111_0003, 64'hD2D2_0000_2222_0002,
                     64'hD1D1_0000_3333_0001, 64'hD0D0_0000_4444_0000},
                    1, 32'hDEAD_BEE0, 7, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0040,
                    {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                     64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_0F0F_F0F0},
                    0, 32'h0000_0040, 4, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 32'hFFFF_FFFF,
                    {64'hC3C3_C3C3_C3C3_C3C3, 64'hC2C2_C2C2_C2C2_C2C2,
                     64'hC1C1_C1C1_C1C1_C1C1, 64'hC0C0_C0C0_C0C0_C0C0},
                    2, 32'hFFFF_FFE0, 10, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 32'h0000_001F,
                    {64'h7777_0000_0000_0004, 64'h6666_0000_0000_0003,
                     64'h5555_0000_0000_0002, 64'h4444_0000_0000_0001},
                    0, 32'h0000_0000, 4, 1'b1};

        rst = 1'b1; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
        address_i = '0; line_i = '0; burst_i = '0;
        repeat (2) @(negedge clk);
        check("rst_line_o", line_o, '0);
        check("rst_resp_o", resp_o, 1'b0);
        check("rst_err_o", err_o, 1'b0);
        check("rst_burst_o", burst_o, '0);
        check("rst_address_o", address_o, '0);
        check("rst_read_o", read_o, 1'b0);
        check("rst_write_o", write_o, 1'b0);
        rst = 1'b0;

        // Stray beat strobes while idle.
        resp_i  = 1'b1;
        burst_i = 64'hDEAD_DEAD_DEAD_DEAD;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_stray_resp", {resp_o, read_o, write_o}, 3'b000);
        end
        resp_i = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_txn(vecs[i]);

        // Reset while beat 2 of a fill is on the bus.
        read_i = 1'b1; address_i = 32'h0000_0100; n = 0; done = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            resp_i = 1'b0;
            if (read_o) begin
                resp_i  = 1'b1;
                burst_i = 64'h1111_0000_0000_0000 + 64'(n);
                if (n == 2) begin
                    rst  = 1'b1;
                    done = 1;
                end
                n++;
            end
        end
        check("reset_reached_beat2", done, 1'b1);
        @(negedge clk);
        check("midrst_outputs", {line_o, burst_o, address_o, resp_o, err_o, read_o, write_o}, '0);
        rst = 1'b0; read_i = 1'b0; resp_i = 1'b0;
        last_fill = '0;
        @(negedge clk);
        check("midrst_no_resp", resp_o, 1'b0);
        run_txn(vecs[0]);

`ifdef CLA_TIMEOUT_EN
        // No beats at all: abort with err_o after TIMEOUT cycles.
        read_i = 1'b1; address_i = 32'h0000_0080; n = 0; done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (resp_o) begin
                check("timeout_err_o", err_o, 1'b1);
                check("timeout_cycles", 32'(n), 32'd8);
                read_i = 1'b0;
                done   = 1;
            end else if (read_o) begin
                n++;
            end
        end
        check("timeout_resp", done, 1'b1);
        @(negedge clk);
        check("timeout_pulse", {resp_o, err_o, read_o}, 3'b000);
`else
        // Without the timeout the burst waits as long as memory takes.
        nt_data = {64'hE3E3_0000_0000_0000, 64'hE2E2_0000_0000_0000,
                   64'hE1E1_0000_0000_0000, 64'hE0E0_0000_0000_0000};
        read_i = 1'b1; address_i = 32'h0000_0080; n = 0; done = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (read_o && !resp_o && !err_o) n++;
        end
        check("no_timeout_wait", 32'(n), 32'd20);
        n = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            resp_i = 1'b0;
            if (resp_o) begin
                check("late_fill_line", line_o, nt_data);
                check("late_fill_err", err_o, 1'b0);
                read_i = 1'b0;
                done   = 1;
            end else if (read_o) begin
                resp_i  = 1'b1;
                burst_i = nt_data[64*n +: 64];
                n++;
            end
        end
        check("late_fill_resp", done, 1'b1);
        @(negedge clk);
`endif

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
